// File: rtl/escape_iter_unit_if.sv
// Pixel request / result bundle for the escape-time engine.
// master drives requests and consumes results; slave is the engine side.
interface escape_iter_unit_if #(
    parameter int WORD_LENGTH = 32,
    parameter int ITER_W      = 10,
    parameter int TAG_W       = 20
) ();
    logic                          in_valid;
    logic                          in_ready;
    logic signed [WORD_LENGTH-1:0] re_pix;
    logic signed [WORD_LENGTH-1:0] im_pix;
    logic signed [WORD_LENGTH-1:0] re_k;
    logic signed [WORD_LENGTH-1:0] im_k;
    logic                          julia;
    logic [ITER_W-1:0]             max_iter;
    logic [TAG_W-1:0]              tag_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [ITER_W-1:0]             out_depth;
    logic                          out_escaped;
    logic [TAG_W-1:0]              tag_out;

    modport master (
        output in_valid, re_pix, im_pix, re_k, im_k, julia, max_iter, tag_in, out_ready,
        input  in_ready, out_valid, out_depth, out_escaped, tag_out
    );

    modport slave (
        input  in_valid, re_pix, im_pix, re_k, im_k, julia, max_iter, tag_in, out_ready,
        output in_ready, out_valid, out_depth, out_escaped, tag_out
    );
endinterface

// File: rtl/escape_iter_unit.sv
// Fixed-point escape-time engine: iterates z <- z^2 + c for one pixel
// (Mandelbrot or Julia) and reports the depth at which |z|^2 exceeds 4,
// or the iteration limit. Two cycles per iteration: multiply, then test/update.
module escape_iter_unit #(
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int ITER_W      = 10,
    parameter int TAG_W       = 20
) (
    input  logic              sysclk,
    input  logic              reset,
    escape_iter_unit_if.slave bus
);
    localparam int PW = 2 * WORD_LENGTH;
    // 4.0 at the product scale (2*FRAC fractional bits)
    localparam logic [PW:0] ESC_LIMIT = (PW + 1)'(1) << (2 * FRAC + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic signed [WORD_LENGTH-1:0] z_re_reg, z_im_reg, c_re_reg, c_im_reg;
    logic signed [PW-1:0]          rr_reg, ii_reg, ri_reg;
    logic [ITER_W-1:0]             depth_reg, max_iter_reg;
    logic [TAG_W-1:0]              tag_reg;
    logic [ITER_W-1:0]             out_depth_reg;
    logic                          out_escaped_reg;
    logic [TAG_W-1:0]              tag_out_reg;

    logic                          in_ready_c, out_valid_c;
    logic [PW:0]                   mag_c;
    logic signed [PW:0]            diff_c;
    logic signed [WORD_LENGTH-1:0] re_next_c, im_next_c;
    logic                          escaped_c, at_limit_c;

    // Escape test and next-z arithmetic from the registered products.
    // Squares are non-negative, so the magnitude sum is exact in PW+1 bits.
    always_comb begin
        mag_c      = {1'b0, rr_reg} + {1'b0, ii_reg};
        diff_c     = {rr_reg[PW-1], rr_reg} - {ii_reg[PW-1], ii_reg};
        escaped_c  = mag_c > ESC_LIMIT;
        at_limit_c = depth_reg == max_iter_reg;
        re_next_c  = WORD_LENGTH'(diff_c >>> FRAC) + c_re_reg;
        // 2*re*im: shifting one bit less than FRAC doubles the product
        im_next_c  = WORD_LENGTH'(ri_reg >>> (FRAC - 1)) + c_im_reg;
    end

    // State register
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next  = state_reg;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = MUL;
            end
            MUL: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (escaped_c || at_limit_c) state_next = DONE;
                else                         state_next = MUL;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load on accept, multiply, then test/update or capture result
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            z_re_reg        <= '0;
            z_im_reg        <= '0;
            c_re_reg        <= '0;
            c_im_reg        <= '0;
            rr_reg          <= '0;
            ii_reg          <= '0;
            ri_reg          <= '0;
            depth_reg       <= '0;
            max_iter_reg    <= '0;
            tag_reg         <= '0;
            out_depth_reg   <= '0;
            out_escaped_reg <= 1'b0;
            tag_out_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        z_re_reg     <= bus.julia ? bus.re_pix : '0;
                        z_im_reg     <= bus.julia ? bus.im_pix : '0;
                        c_re_reg     <= bus.julia ? bus.re_k : bus.re_pix;
                        c_im_reg     <= bus.julia ? bus.im_k : bus.im_pix;
                        max_iter_reg <= bus.max_iter;
                        tag_reg      <= bus.tag_in;
                        depth_reg    <= '0;
                    end
                end
                MUL: begin
                    rr_reg <= PW'(z_re_reg) * PW'(z_re_reg);
                    ii_reg <= PW'(z_im_reg) * PW'(z_im_reg);
                    ri_reg <= PW'(z_re_reg) * PW'(z_im_reg);
                end
                CHECK: begin
                    if (escaped_c || at_limit_c) begin
                        out_escaped_reg <= escaped_c;
                        out_depth_reg   <= depth_reg;
                        tag_out_reg     <= tag_reg;
                    end else begin
                        z_re_reg  <= re_next_c;
                        z_im_reg  <= im_next_c;
                        depth_reg <= depth_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_depth   = out_depth_reg;
    assign bus.out_escaped = out_escaped_reg;
    assign bus.tag_out     = tag_out_reg;
endmodule

// File: tb/tb_escape_iter_unit.sv
// Bench for escape_iter_unit: directed boundary pixels, randomized pixels
// against a plain-arithmetic escape-time model, back-pressure and reset.
module tb_escape_iter_unit;
    localparam int W    = 32;
    localparam int FRAC = 28;
    localparam int IW   = 10;
    localparam int TW   = 20;

    logic sysclk;
    logic reset;
    int   checks;
    int   failures;

    escape_iter_unit_if #(.WORD_LENGTH(W), .ITER_W(IW), .TAG_W(TW)) bus ();

    escape_iter_unit #(.WORD_LENGTH(W), .FRAC(FRAC), .ITER_W(IW), .TAG_W(TW)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Escape-time reference: iterate the complex recurrence directly.
    function automatic void ref_model(input logic jl, input int rp, input int ip,
                                      input int rk, input int ik, input int unsigned mi,
                                      output int unsigned d, output bit esc);
        int zr, zi, cr, ci;
        longint rr, ii, ri;
        logic [64:0] mag;
        logic [64:0] lim;
        lim = 65'd1 << 58;
        if (jl) begin zr = rp; zi = ip; cr = rk; ci = ik; end
        else    begin zr = 0;  zi = 0;  cr = rp; ci = ip; end
        d = 0;
        esc = 1'b0;
        for (int n = 0; n <= int'(mi); n++) begin
            d   = n;
            rr  = longint'(zr) * longint'(zr);
            ii  = longint'(zi) * longint'(zi);
            ri  = longint'(zr) * longint'(zi);
            mag = 65'(rr) + 65'(ii);
            if (mag > lim) begin
                esc = 1'b1;
                return;
            end
            if (n == int'(mi)) return;
            zr = int'((rr - ii) >>> FRAC) + cr;
            zi = int'(ri >>> (FRAC - 1)) + ci;
        end
    endfunction

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.re_pix    = '0;
        bus.im_pix    = '0;
        bus.re_k      = '0;
        bus.im_k      = '0;
        bus.julia     = 1'b0;
        bus.max_iter  = '0;
        bus.tag_in    = '0;
        repeat (3) @(posedge sysclk);
        #2 reset = 1'b0;
        @(posedge sysclk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_depth !== '0) begin failures++; $display("FAIL reset_out_depth got=%0d want=0", bus.out_depth); end
        checks++; if (bus.out_escaped !== 1'b0) begin failures++; $display("FAIL reset_out_escaped got=%b want=0", bus.out_escaped); end
        checks++; if (bus.tag_out !== '0) begin failures++; $display("FAIL reset_tag_out got=%h want=0", bus.tag_out); end
        $display("reset: in_ready=%b out_valid=%b out_depth=%0d", bus.in_ready, bus.out_valid, bus.out_depth);
    endtask

    // One pixel through the engine. want_d < 0 means expectations come from the model.
    task automatic test_pixel(input string name, input logic jl, input int rp, input int ip,
                              input int rk, input int ik, input int unsigned mi,
                              input logic [TW-1:0] tg, input int want_d, input bit want_e);
        int unsigned exp_d;
        bit          exp_e;
        int          n;
        int          lim;
        if (want_d < 0) begin
            ref_model(jl, rp, ip, rk, ik, mi, exp_d, exp_e);
        end else begin
            exp_d = int'(want_d);
            exp_e = want_e;
        end
        bus.julia    = jl;
        bus.re_pix   = rp;
        bus.im_pix   = ip;
        bus.re_k     = rk;
        bus.im_k     = ik;
        bus.max_iter = mi[IW-1:0];
        bus.tag_in   = tg;
        bus.in_valid = 1'b1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s_in_ready got=%b want=1", name, bus.in_ready); end
        @(posedge sysclk); #1;
        // Inputs change after acceptance; the engine must ignore them
        bus.in_valid = 1'b0;
        bus.julia    = ~jl;
        bus.re_pix   = $urandom;
        bus.im_pix   = $urandom;
        bus.re_k     = $urandom;
        bus.im_k     = $urandom;
        bus.max_iter = IW'($urandom);
        bus.tag_in   = TW'($urandom);
        n   = 0;
        lim = 2 * (int'(mi) + 1) + 8;
        while (bus.out_valid !== 1'b1 && n < lim) begin
            @(posedge sysclk); #1;
            n++;
        end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL %s_timeout out_valid=%b after %0d cycles", name, bus.out_valid, n); end
        checks++; if (n != 2 * (int'(exp_d) + 1)) begin failures++; $display("FAIL %s_latency got=%0d want=%0d", name, n, 2 * (exp_d + 1)); end
        checks++; if (bus.out_depth !== IW'(exp_d)) begin failures++; $display("FAIL %s_depth got=%0d want=%0d", name, bus.out_depth, exp_d); end
        checks++; if (bus.out_escaped !== exp_e) begin failures++; $display("FAIL %s_escaped got=%b want=%b", name, bus.out_escaped, exp_e); end
        checks++; if (bus.tag_out !== tg) begin failures++; $display("FAIL %s_tag got=%h want=%h", name, bus.tag_out, tg); end
        $display("%s: julia=%b pix=(%h,%h) k=(%h,%h) max=%0d depth=%0d esc=%b lat=%0d tag=%h",
                 name, jl, rp, ip, rk, ik, mi, bus.out_depth, bus.out_escaped, n, bus.tag_out);
        bus.out_ready = 1'b1;
        @(posedge sysclk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL %s_post_valid got=%b want=0", name, bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s_post_ready got=%b want=1", name, bus.in_ready); end
        checks++; if (bus.out_depth !== IW'(exp_d)) begin failures++; $display("FAIL %s_depth_hold got=%0d want=%0d", name, bus.out_depth, exp_d); end
    endtask

    task automatic test_back_to_back(input int count);
        int rp, ip, rk, ik;
        int unsigned mi;
        logic jl;
        for (int i = 0; i < count; i++) begin
            jl = 1'($urandom_range(0, 1));
            // Region roughly covering the Mandelbrot set: re in [-2.5,1.0], im in [-1.25,1.25]
            rp = int'($urandom_range(0, 32'h3800_0000)) - 32'sh2800_0000;
            ip = int'($urandom_range(0, 32'h2800_0000)) - 32'sh1400_0000;
            rk = int'($urandom_range(0, 32'h2000_0000)) - 32'sh1000_0000;
            ik = int'($urandom_range(0, 32'h2000_0000)) - 32'sh1000_0000;
            mi = $urandom_range(0, 40);
            test_pixel($sformatf("rand%0d", i), jl, rp, ip, rk, ik, mi, TW'($urandom), -1, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] tg;
        int n;
        tg = 20'h1C3D7;
        bus.julia    = 1'b0;
        bus.re_pix   = 32'sh2000_0000;
        bus.im_pix   = '0;
        bus.max_iter = 10'd200;
        bus.tag_in   = tg;
        bus.in_valid = 1'b1;
        @(posedge sysclk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(posedge sysclk); #1;
            n++;
        end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout out_valid=%b", bus.out_valid); end
        for (int c = 0; c < 5; c++) begin
            @(posedge sysclk); #1;
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_%0d got=%b want=1", c, bus.out_valid); end
            checks++; if (bus.out_depth !== 10'd2) begin failures++; $display("FAIL bp_depth_%0d got=%0d want=2", c, bus.out_depth); end
            checks++; if (bus.tag_out !== tg) begin failures++; $display("FAIL bp_tag_%0d got=%h want=%h", c, bus.tag_out, tg); end
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_%0d got=%b want=0", c, bus.in_ready); end
        end
        // Offer a new pixel in the handshake cycle: it must not be taken in the same cycle
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge sysclk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b want=1", bus.in_ready); end
        $display("backpressure: depth=%0d tag=%h in_ready=%b", bus.out_depth, bus.tag_out, bus.in_ready);
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.julia    = 1'b0;
        bus.re_pix   = '0;
        bus.im_pix   = '0;
        bus.max_iter = 10'd100;
        bus.tag_in   = 20'h0BEEF;
        bus.in_valid = 1'b1;
        @(posedge sysclk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", bus.in_ready); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_depth !== '0) begin failures++; $display("FAIL rmid_out_depth got=%0d want=0", bus.out_depth); end
        @(posedge sysclk);
        #2 reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 220; c++) begin
            @(posedge sysclk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rmid_stale_result got=%0d want=0 valid cycles", seen); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rmid_idle got=%b want=1", bus.in_ready); end
        $display("reset_mid: stale_valid_cycles=%0d in_ready=%b", seen, bus.in_ready);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_pixel("mandel_c2",    1'b0, 32'sh2000_0000, 0, 0, 0, 200, 20'h00001, 2,   1'b1);
        test_pixel("mandel_cm2",   1'b0, 32'shE000_0000, 0, 0, 0, 200, 20'h00002, 200, 1'b0);
        test_pixel("mandel_max0",  1'b0, 0, 0, 0, 0, 0, 20'h00003, 0, 1'b0);
        test_pixel("julia_p3",     1'b1, 32'sh3000_0000, 0, 0, 0, 10, 20'h00004, 0, 1'b1);
        test_pixel("julia_k025",   1'b1, 0, 0, 32'sh0400_0000, 0, 50, 20'h5A5A5, 50, 1'b0);
        test_pixel("julia_max0_esc", 1'b1, 32'sh3000_0000, 32'sh1000_0000, 0, 0, 0, 20'h00006, 0, 1'b1);
        test_back_to_back(24);
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/escape_iter_unit.md
Name: escape_iter_unit

Overview:
- Parametrised fixed-point escape-time engine. Computes the iteration depth of z <- z^2 + c for one pixel.
- Supports Mandelbrot mode (z0=0, c=pixel) and Julia mode (z0=pixel, c=constant).
- Uses a valid/ready handshake on both input and output. A tag passes through with each pixel.
- One or more instances sit between the pixel-coordinate generator and the colour mapper.

Parameters:
- WORD_LENGTH, 32: signed fixed-point word width of z and c.
- FRAC, 28: fractional bits; the value 1.0 is 1<<FRAC.
- ITER_W, 10: width of max_iter and out_depth.
- TAG_W, 20: width of the pass-through pixel tag.

Ports:
- sysclk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel request valid.
- in_ready  out  1  engine can accept a pixel.
- re_pix  in  WORD_LENGTH  signed pixel coordinate, real part.
- im_pix  in  WORD_LENGTH  signed pixel coordinate, imaginary part.
- re_k  in  WORD_LENGTH  Julia constant, real part.
- im_k  in  WORD_LENGTH  Julia constant, imaginary part.
- julia  in  1  0 = Mandelbrot, 1 = Julia.
- max_iter  in  ITER_W  iteration limit.
- tag_in  in  TAG_W  pixel tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_depth  out  ITER_W  iteration count.
- out_escaped  out  1  1 = escaped; 0 = hit max_iter.
- tag_out  out  TAG_W  tag of the result.

Behaviour:
- Clock and reset: one clock (sysclk); reset is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - in_ready = 1.
  - out_valid = 0.
  - out_depth, out_escaped, tag_out, z, c, depth = 0.
- Reset mid-iteration aborts the pixel; no result is emitted.
- States: IDLE, MUL, CHECK, DONE.
- IDLE:
  - in_ready = 1 here only.
  - On the accept edge (in_valid & in_ready), latch the following and go to MUL:
    - julia=0: z=0, c=pix.
    - julia=1: z=pix, c=k.
    - max_iter and tag_in.
    - depth=0.
  - All inputs are sampled only at this edge; later changes are ignored.
- MUL:
  - Register three full-precision signed 2*WORD_LENGTH products: re*re, im*im, re*im.
  - Go to CHECK.
- CHECK (escape test on the current z, before any update):
  - mag = (re*re + im*im) computed in 2*WORD_LENGTH+1 bits, no overflow.
  - escaped = mag > (4 << 2*FRAC), strictly greater; |z|^2 = 4 exactly does not escape.
  - If escaped: out_escaped=1, out_depth=depth, go to DONE.
  - Else if depth == max_iter: out_escaped=0, out_depth=depth, go to DONE.
  - Else update and go to MUL:
    - re <= trunc_W((re*re - im*im) >>> FRAC) + c_re.
    - im <= trunc_W((re*im) >>> (FRAC-1)) + c_im.
    - depth <= depth + 1.
  - Update arithmetic: arithmetic right shift; truncation and addition wrap modulo 2^WORD_LENGTH.
- Cost: 2 cycles per iteration. A result with depth d asserts out_valid exactly 2*(d+1) cycles after the accept edge.
- DONE:
  - out_valid = 1; out_depth, out_escaped and tag_out are held stable while out_ready = 0.
  - On out_valid & out_ready: clear out_valid, go to IDLE.
  - A new pixel is accepted at the earliest on the next edge; no same-cycle accept.
- max_iter = 0 yields depth 0 after one check; escaped is set only if |z0|^2 > 4.
- depth never exceeds max_iter; no counter wrap.
- out_depth and out_escaped keep their last result after the handshake until the next result.

Test Plan:
- Mandelbrot, c = 2.0 (0x2000_0000, 0), max_iter = 200:
  - accept at edge E.
  - Required: out_valid at E+6, out_depth = 2, out_escaped = 1.
- Mandelbrot, c = -2.0 (0xE000_0000, 0), max_iter = 200 (|z|^2 = 4 boundary):
  - Required: out_depth = 200, out_escaped = 0, out_valid at E+402.
- Mandelbrot, c = 0, max_iter = 0:
  - Required: out_depth = 0, out_escaped = 0 at E+2.
- Julia, pix = 3.0 (0x3000_0000), k = 0:
  - Required: out_depth = 0, out_escaped = 1.
- Julia, pix = 0, k = 0.25: never escapes.
  - Required: out_depth = max_iter = 50, out_escaped = 0, tag_out = tag_in (0x5A5A5).
- Back-pressure: c = 2.0, out_ready held low for 5 cycles.
  - Required: out_valid, out_depth, tag_out stable; in_ready = 0 throughout.
  - Required: after the handshake, in_ready = 1 on the next cycle.
- Reset asserted mid-MUL for a c = 0 pixel:
  - Required: out_valid = 0 and in_ready = 1 immediately (asynchronous); no stale result after reset release.
